// File: rtl/uart_rx_fifo_controller.sv
// UART receiver: 2-flop sync, 3-sample majority vote, optional parity,
// show-ahead receive FIFO with sticky overrun/framing/parity flags.
module uart_rx_fifo_controller #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clock_50,
  input  logic                          Resetn,
  input  logic                          Enable,
  input  logic                          Unload_data,
  input  logic                          Clear_errors,
  input  logic                          UART_RX_I,
  output logic [DATA_BITS-1:0]          RX_data,
  output logic                          Empty,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Fill_count,
  output logic                          Overrun,
  output logic                          Frame_error,
  output logic                          Parity_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
  localparam logic [3:0]    NBITS  = 4'(DATA_BITS);
  localparam logic [FW-1:0] DEPTH_C = FW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q;
  logic                 rx_m_q;
  logic                 rx_s_q;
  logic                 rx_d_q;
  logic [CW-1:0]        bit_cnt_q;
  logic [3:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 smp0_q;
  logic                 smp1_q;
  logic                 par_err_q;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr_q;
  logic [AW-1:0]        rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        wr_ptr_d;
  logic [FW-1:0]        cnt_q;
  logic [FW-1:0]        cnt_d;
  logic                 empty_q;
  logic                 full_q;
  logic                 ovr_q;
  logic                 fer_q;
  logic                 per_q;

  logic fall;
  logic at_last;
  logic at_dec;
  logic maj;
  logic par_x;
  logic par_bad;
  logic stop_dec;
  logic pop;
  logic good;
  logic push;
  logic set_ovr;
  logic set_fer;
  logic set_per;

  assign fall    = rx_d_q & ~rx_s_q;
  assign at_last = (bit_cnt_q == C_LAST);
  assign at_dec  = (bit_cnt_q == C_DEC);
  assign maj     = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
  assign par_x   = (^shift_q) ^ maj;
  assign par_bad = (PARITY_MODE == 2) ? ~par_x : par_x;

  assign stop_dec = (state_q == S_STOP) && at_dec;
  assign pop      = Unload_data & ~empty_q;
  assign set_fer  = stop_dec & ~maj;
  assign set_per  = stop_dec & maj & par_err_q;
  assign good     = stop_dec & maj & ~par_err_q;
  assign set_ovr  = good & full_q & ~pop;
  assign push     = good & (~full_q | pop);

  // Two-flop synchronizer plus a delay flop for falling-edge detect.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      rx_m_q <= UART_RX_I;
      rx_s_q <= rx_m_q;
      rx_d_q <= rx_s_q;
    end
  end

  // Frame FSM: bit timing, majority samples, data shift and parity check.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      smp0_q    <= 1'b1;
      smp1_q    <= 1'b1;
      par_err_q <= 1'b0;
    end else begin
      bit_cnt_q <= at_last ? '0 : bit_cnt_q + 1'b1;
      if (bit_cnt_q == C_S0) smp0_q <= rx_s_q;
      if (bit_cnt_q == C_S1) smp1_q <= rx_s_q;
      unique case (state_q)
        S_IDLE: begin
          if (fall && Enable) begin
            state_q   <= S_START;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
          end
        end
        S_START: begin
          if (at_dec && maj) begin
            state_q <= S_IDLE;
          end else if (at_last) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (at_dec) begin
            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
          end
          if (at_last && idx_q == NBITS) begin
            state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (at_dec) par_err_q <= par_bad;
          if (at_last) state_q <= S_STOP;
        end
        S_STOP: begin
          if (at_dec) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      ovr_q <= 1'b0;
      fer_q <= 1'b0;
      per_q <= 1'b0;
    end else begin
      ovr_q <= set_ovr | (ovr_q & ~Clear_errors);
      fer_q <= set_fer | (fer_q & ~Clear_errors);
      per_q <= set_per | (per_q & ~Clear_errors);
    end
  end

  // Next pointer and occupancy for the FIFO.
  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and registered Empty/Full derived from the next count.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (cnt_d == DEPTH_C);
    end
  end

  // FIFO storage, cleared on reset so the head reads 0 when empty.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign RX_data      = mem_q[rd_ptr_q];
  assign Empty        = empty_q;
  assign Full         = full_q;
  assign Fill_count   = cnt_q;
  assign Overrun      = ovr_q;
  assign Frame_error  = fer_q;
  assign Parity_error = per_q;

endmodule

// File: tb/tb_uart_rx_fifo_controller.sv
// Bench: queue-based receive model checked every cycle on the 8N1 unit,
// literal checks on a 7E1 unit for the parity scenarios.
module tb_uart_rx_fifo_controller;

  localparam int CPB   = 8;
  localparam int H     = CPB / 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic un0 = 1'b0, clr0 = 1'b0, rx0 = 1'b1;
  logic un1 = 1'b0, clr1 = 1'b0, rx1 = 1'b1;

  logic [7:0] d0;
  logic       e0, f0, ov0, fe0, pe0;
  logic [2:0] fc0;
  logic [6:0] d1;
  logic       e1, f1, ov1, fe1, pe1;
  logic [2:0] fc1;

  uart_rx_fifo_controller #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(DEPTH)
  ) dut0 (
    .Clock_50(clk), .Resetn(rst_n), .Enable(en), .Unload_data(un0),
    .Clear_errors(clr0), .UART_RX_I(rx0), .RX_data(d0), .Empty(e0),
    .Full(f0), .Fill_count(fc0), .Overrun(ov0), .Frame_error(fe0),
    .Parity_error(pe0)
  );

  uart_rx_fifo_controller #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .Clock_50(clk), .Resetn(rst_n), .Enable(en), .Unload_data(un1),
    .Clear_errors(clr1), .UART_RX_I(rx1), .RX_data(d1), .Empty(e1),
    .Full(f1), .Fill_count(fc1), .Overrun(ov1), .Frame_error(fe1),
    .Parity_error(pe1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         ferr;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] mq[$];
  bit         m_ov = 0, m_fe = 0;
  bit         m_pop, m_push, m_sov, m_sfe;
  ev_t        m_ev;

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  bit done;

  // Reference model: a word lands at its stop decision edge by the rules.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      m_ov = 0;
      m_fe = 0;
    end else begin
      m_pop  = un0 && mq.size() != 0;
      m_push = 0;
      m_sov  = 0;
      m_sfe  = 0;
      if (pend.size() != 0 && pend[0].at == cyc + 1) begin
        m_ev = pend.pop_front();
        if (m_ev.ferr) m_sfe = 1;
        else if (mq.size() == DEPTH && !m_pop) m_sov = 1;
        else m_push = 1;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_ev.data);
      m_ov = m_sov | (m_ov & !clr0);
      m_fe = m_sfe | (m_fe & !clr0);
    end
  end

  // Every-cycle comparison of the 8N1 unit against the model.
  initial forever begin
    @(negedge clk);
    checks++;
    if (e0 !== (mq.size() == 0) || f0 !== (mq.size() == DEPTH) ||
        fc0 !== 3'(mq.size()) || ov0 !== m_ov || fe0 !== m_fe ||
        pe0 !== 1'b0 || (mq.size() != 0 && d0 !== mq[0])) begin
      errors++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL model cyc=%0d got e=%b f=%b n=%0d d=%h ov=%b fe=%b pe=%b want e=%b n=%0d d=%h ov=%b fe=%b",
                 cyc, e0, f0, fc0, d0, ov0, fe0, pe0, mq.size() == 0,
                 mq.size(), mq.size() != 0 ? mq[0] : 8'h00, m_ov, m_fe);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setl(input int ln, input logic v);
    if (ln == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic send(input int ln, input int nb, input logic [7:0] d,
                      input int par, input logic stop, input int gbit);
    ev_t ev;
    int  np;
    np = (par >= 0) ? 1 : 0;
    if (ln == 0) begin
      ev.at   = cyc + 3 + CPB * (1 + nb + np) + H + 2;
      ev.data = d;
      ev.ferr = !stop;
      pend.push_back(ev);
    end
    setl(ln, 1'b0);
    wt(CPB);
    for (int i = 0; i < nb; i++) begin
      setl(ln, d[i]);
      if (i == gbit) begin
        wt(H + 1);
        setl(ln, !d[i]);
        wt(1);
        setl(ln, d[i]);
        wt(CPB - H - 2);
      end else begin
        wt(CPB);
      end
    end
    if (np == 1) begin
      setl(ln, par[0]);
      wt(CPB);
    end
    setl(ln, stop);
    wt(CPB);
  endtask

  task automatic pop0();
    un0 = 1'b1;
    wt(1);
    un0 = 1'b0;
  endtask

  task automatic clear0();
    clr0 = 1'b1;
    wt(1);
    clr0 = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       st;
    int         g;
    int         guard;

    wt(3);
    rst_n = 1'b1;
    wt(2);
    chk("rst_data", d0, 0);
    chk("rst_empty", e0, 1);
    chk("rst_full", f0, 0);
    chk("rst_count", fc0, 0);
    chk("rst_errs", {ov0, fe0, pe0}, 0);
    chk("rst_empty1", e1, 1);

    send(0, 8, 8'hA5, -1, 1'b1, -1);
    wt(2);
    chk("basic_data", d0, 8'hA5);
    chk("basic_empty", e0, 0);
    chk("basic_count", fc0, 1);
    chk("basic_errs", {ov0, fe0, pe0}, 0);
    pop0();
    wt(1);
    chk("basic_popped", e0, 1);

    for (int k = 1; k <= 5; k++) send(0, 8, 8'(k), -1, 1'b1, -1);
    wt(2);
    chk("ovr_full", f0, 1);
    chk("ovr_count", fc0, 4);
    chk("ovr_flag", ov0, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovr_order", d0, k);
      pop0();
    end
    wt(1);
    chk("ovr_drained", e0, 1);
    clear0();
    wt(1);
    chk("ovr_cleared", ov0, 0);

    send(0, 8, 8'h3C, -1, 1'b0, -1);
    wt(CPB * 30);
    chk("frame_flag", fe0, 1);
    chk("frame_nopush", e0, 1);
    setl(0, 1'b1);
    wt(CPB);
    send(0, 8, 8'h11, -1, 1'b1, -1);
    wt(2);
    chk("break_recover", d0, 8'h11);
    pop0();
    clear0();
    wt(1);
    chk("frame_cleared", fe0, 0);

    send(0, 8, 8'h96, -1, 1'b1, 3);
    wt(2);
    chk("glitch_data", d0, 8'h96);
    pop0();
    setl(0, 1'b0);
    wt(2);
    setl(0, 1'b1);
    wt(CPB * 3);
    chk("false_start_empty", e0, 1);
    chk("false_start_errs", {ov0, fe0, pe0}, 0);

    for (int k = 0; k < 4; k++) send(0, 8, 8'hA0 + 8'(k), -1, 1'b1, -1);
    wt(2);
    chk("simul_prefull", f0, 1);
    fork
      send(0, 8, 8'hA4, -1, 1'b1, -1);
      begin
        wt(CPB * 10);
        un0 = 1'b1;
        wt(1);
        un0 = 1'b0;
      end
    join
    wt(2);
    chk("simul_count", fc0, 4);
    chk("simul_ovr", ov0, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("simul_order", d0, 8'hA0 + k);
      pop0();
    end

    send(1, 7, 8'h55, 1, 1'b1, -1);
    wt(2);
    chk("par_flag", pe1, 1);
    chk("par_nopush", e1, 1);
    send(1, 7, 8'h55, 0, 1'b1, -1);
    wt(2);
    chk("par_good", d1, 7'h55);
    chk("par_good_empty", e1, 0);
    clr1 = 1'b1;
    wt(1);
    clr1 = 1'b0;
    wt(1);
    chk("par_cleared", pe1, 0);

    done = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          rd = 8'($urandom);
          st = ($urandom % 8) != 0;
          g  = ($urandom % 4 == 0) ? int'($urandom % 8) : -1;
          send(0, 8, rd, -1, st, g);
          if (!st) begin
            setl(0, 1'b1);
            wt(CPB);
          end
          wt($urandom % 4);
        end
        done = 1;
      end
      begin
        while (!done) begin
          un0  = ($urandom % 3) == 0;
          clr0 = ($urandom % 50) == 0;
          wt(1);
        end
        un0  = 1'b0;
        clr0 = 1'b0;
      end
    join
    wt(3);
    guard = 0;
    while (!e0 && guard < 10) begin
      pop0();
      guard++;
    end

    send(0, 8, 8'h5A, -1, 1'b1, -1);
    wt(2);
    fork
      send(0, 8, 8'h00, -1, 1'b1, -1);
      begin
        wt(30);
        rst_n = 1'b0;
      end
    join
    wt(2);
    rst_n = 1'b1;
    wt(2);
    chk("mid_rst_data", d0, 0);
    chk("mid_rst_empty", e0, 1);
    chk("mid_rst_full", f0, 0);
    chk("mid_rst_count", fc0, 0);
    chk("mid_rst_errs", {ov0, fe0, pe0}, 0);
    chk("mid_rst_empty1", e1, 1);
    wt(CPB * 12);
    chk("mid_rst_quiet", e0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
